// File: rtl/mod113_pkg.sv
// Shared constants, FSM state type and the mod-113 two-threshold reduction
// used by the residue accumulator and the parallel adder tree.
package mod113_pkg;

   localparam int unsigned MODULUS = 113;
   localparam int unsigned RES_W   = 7;
   localparam int unsigned SUM_W   = 9;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Sum of a canonical residue and a 7-bit term never reaches 3*113,
   // so at most two subtractions of the modulus are needed.
   function automatic logic [RES_W-1:0] mod113_reduce(input logic [SUM_W-1:0] s);
      logic [RES_W-1:0] r;
      if (s >= SUM_W'(2 * MODULUS)) begin
         r = RES_W'(s - SUM_W'(2 * MODULUS));
      end else if (s >= SUM_W'(MODULUS)) begin
         r = RES_W'(s - SUM_W'(MODULUS));
      end else begin
         r = RES_W'(s);
      end
      return r;
   endfunction

endpackage

// File: rtl/mod113_add_reduce.sv
// Combinational a + b folded back to the canonical range 0..112.
module mod113_add_reduce
   import mod113_pkg::*;
(
   input  logic [RES_W-1:0] i_a,
   input  logic [RES_W-1:0] i_b,
   output logic [RES_W-1:0] o_sum_c
);

   logic [SUM_W-1:0] w_sum;

   always_comb begin
      w_sum   = SUM_W'(i_a) + SUM_W'(i_b);
      o_sum_c = mod113_reduce(w_sum);
   end

endmodule

// File: rtl/mod113_residue_accumulator.sv
// Streams weighted partial residues, keeps a running sum mod 113 and presents
// the frame residue, term count and overflow flag, held under back-pressure.
module mod113_residue_accumulator
   import mod113_pkg::*;
#(
   parameter int unsigned MAX_TERMS = 84,
   parameter int unsigned CNT_W     = 7
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [RES_W-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [RES_W-1:0] out_residue,
   output logic [CNT_W-1:0] out_count,
   output logic             out_overflow
);

   state_t           r_state,        w_state_nxt;
   logic [RES_W-1:0] r_acc,          w_acc_nxt;
   logic [CNT_W-1:0] r_cnt,          w_cnt_nxt;
   logic             r_in_ready,     w_in_ready_nxt;
   logic             r_out_valid,    w_out_valid_nxt;
   logic [RES_W-1:0] r_out_residue,  w_out_residue_nxt;
   logic [CNT_W-1:0] r_out_count,    w_out_count_nxt;
   logic             r_out_overflow, w_out_overflow_nxt;

   logic [RES_W-1:0] w_sum;
   logic             w_hs;
   logic             w_at_max;
   logic [CNT_W-1:0] w_cnt_inc;

   mod113_add_reduce u_add (
      .i_a     (r_acc),
      .i_b     (in_data),
      .o_sum_c (w_sum)
   );

   assign w_hs      = in_valid & r_in_ready;
   assign w_at_max  = (r_cnt == CNT_W'(MAX_TERMS - 1));
   assign w_cnt_inc = CNT_W'(r_cnt + 1'b1);

   // Next-state and next-output decode; everything holds unless a handshake
   // or an output release happens.
   always_comb begin
      w_state_nxt        = r_state;
      w_acc_nxt          = r_acc;
      w_cnt_nxt          = r_cnt;
      w_in_ready_nxt     = r_in_ready;
      w_out_valid_nxt    = r_out_valid;
      w_out_residue_nxt  = r_out_residue;
      w_out_count_nxt    = r_out_count;
      w_out_overflow_nxt = r_out_overflow;
      case (r_state)
         IDLE, ACCUM: begin
            if (w_hs) begin
               if (in_last || w_at_max) begin
                  w_state_nxt        = DONE;
                  w_out_residue_nxt  = w_sum;
                  w_out_count_nxt    = w_cnt_inc;
                  w_out_overflow_nxt = ~in_last & w_at_max;
                  w_acc_nxt          = '0;
                  w_cnt_nxt          = '0;
                  w_in_ready_nxt     = 1'b0;
                  w_out_valid_nxt    = 1'b1;
               end else begin
                  w_state_nxt = ACCUM;
                  w_acc_nxt   = w_sum;
                  w_cnt_nxt   = w_cnt_inc;
               end
            end
         end
         DONE: begin
            if (out_ready) begin
               w_state_nxt     = IDLE;
               w_in_ready_nxt  = 1'b1;
               w_out_valid_nxt = 1'b0;
            end
         end
         default: begin
            w_state_nxt     = IDLE;
            w_acc_nxt       = '0;
            w_cnt_nxt       = '0;
            w_in_ready_nxt  = 1'b1;
            w_out_valid_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= IDLE;
         r_acc          <= '0;
         r_cnt          <= '0;
         r_in_ready     <= 1'b1;
         r_out_valid    <= 1'b0;
         r_out_residue  <= '0;
         r_out_count    <= '0;
         r_out_overflow <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_acc          <= w_acc_nxt;
         r_cnt          <= w_cnt_nxt;
         r_in_ready     <= w_in_ready_nxt;
         r_out_valid    <= w_out_valid_nxt;
         r_out_residue  <= w_out_residue_nxt;
         r_out_count    <= w_out_count_nxt;
         r_out_overflow <= w_out_overflow_nxt;
      end
   end

   assign in_ready     = r_in_ready;
   assign out_valid    = r_out_valid;
   assign out_residue  = r_out_residue;
   assign out_count    = r_out_count;
   assign out_overflow = r_out_overflow;

endmodule

// File: tb/tb_mod113_residue_accumulator.sv
// Bench for mod113_residue_accumulator: fixed frame table, hand-written corner
// sequences and random frames against a plain sum-mod-113 reference.
module tb_mod113_residue_accumulator;

   localparam int unsigned MAX_T = 84;
   localparam int unsigned CW    = 7;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [6:0]    in_data;
   logic          in_last;
   logic          out_valid;
   logic          out_ready;
   logic [6:0]    out_residue;
   logic [CW-1:0] out_count;
   logic          out_overflow;

   mod113_residue_accumulator #(.MAX_TERMS(MAX_T), .CNT_W(CW)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_last      (in_last),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_residue  (out_residue),
      .out_count    (out_count),
      .out_overflow (out_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference: plain integer sum of the accepted terms, reduced only at the end.
   int m_sum = 0;
   int m_cnt = 0;
   bit m_ov  = 0;
   int m_res = 0;
   int m_ocnt = 0;
   bit m_ovf = 0;

   typedef struct {
      int n;
      int d[4];
      int exp_res;
      int exp_cnt;
      bit exp_ovf;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_outputs();
      chk("in_ready", int'(in_ready), int'(!m_ov));
      chk("out_valid", int'(out_valid), int'(m_ov));
      if (m_ov) begin
         chk("out_residue", int'(out_residue), m_res);
         chk("out_count", int'(out_count), m_ocnt);
         chk("out_overflow", int'(out_overflow), int'(m_ovf));
      end
   endtask

   task automatic do_reset(input bit v);
      rst = 1'b1; in_valid = v; in_data = 7'd9; in_last = 1'b0; out_ready = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      m_sum = 0; m_cnt = 0; m_ov = 0; m_res = 0; m_ocnt = 0; m_ovf = 0;
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_residue", int'(out_residue), 0);
      chk("rst_out_count", int'(out_count), 0);
      chk("rst_out_overflow", int'(out_overflow), 0);
   endtask

   task automatic drive_cycle(input bit v, input int d, input bit l, input bit ordy,
                              output bit hs, output bit term);
      in_valid = v; in_data = 7'(d); in_last = l; out_ready = ordy;
      hs = 0; term = 0;
      if (m_ov) begin
         if (ordy) m_ov = 0;
      end else if (v) begin
         hs = 1;
         m_sum += d;
         m_cnt++;
         if (l || m_cnt == int'(MAX_T)) begin
            term   = 1;
            m_ov   = 1;
            m_res  = m_sum % 113;
            m_ocnt = m_cnt;
            m_ovf  = !l;
            m_sum  = 0;
            m_cnt  = 0;
         end
      end
      @(posedge clk); #1;
      check_outputs();
   endtask

   task automatic expect_result(input string name, input int res, input int cnt, input bit ovf);
      chk({name, "_valid"}, int'(out_valid), 1);
      chk({name, "_residue"}, int'(out_residue), res);
      chk({name, "_count"}, int'(out_count), cnt);
      chk({name, "_overflow"}, int'(out_overflow), int'(ovf));
   endtask

   initial begin
      bit hs, term;
      int len, idx, frames;

      vecs[0] = '{n: 2, d: '{112, 127, 0, 0}, exp_res: 13, exp_cnt: 2, exp_ovf: 0};
      vecs[1] = '{n: 1, d: '{113, 0, 0, 0},   exp_res: 0,  exp_cnt: 1, exp_ovf: 0};
      vecs[2] = '{n: 1, d: '{127, 0, 0, 0},   exp_res: 14, exp_cnt: 1, exp_ovf: 0};
      vecs[3] = '{n: 2, d: '{60, 60, 0, 0},   exp_res: 7,  exp_cnt: 2, exp_ovf: 0};
      vecs[4] = '{n: 4, d: '{127, 127, 127, 127}, exp_res: 56, exp_cnt: 4, exp_ovf: 0};
      vecs[5] = '{n: 3, d: '{0, 0, 0, 0},    exp_res: 0,  exp_cnt: 3, exp_ovf: 0};

      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
      do_reset(1'b0);

      // Table frames, back to back with out_ready held high.
      for (int i = 0; i < 6; i++) begin
         for (int k = 0; k < vecs[i].n; k++)
            drive_cycle(1'b1, vecs[i].d[k], k == vecs[i].n - 1, 1'b1, hs, term);
         expect_result($sformatf("vec%0d", i), vecs[i].exp_res, vecs[i].exp_cnt, vecs[i].exp_ovf);
         drive_cycle(1'b0, 0, 1'b0, 1'b1, hs, term);
      end

      // Force-terminated frame of 84 ones, then a clean single-term frame.
      for (int k = 0; k < 84; k++) drive_cycle(1'b1, 1, 1'b0, 1'b0, hs, term);
      expect_result("ovf84", 84, 84, 1'b1);
      drive_cycle(1'b0, 0, 1'b0, 1'b1, hs, term);
      drive_cycle(1'b1, 5, 1'b1, 1'b1, hs, term);
      expect_result("after_ovf", 5, 1, 1'b0);
      drive_cycle(1'b0, 0, 1'b0, 1'b1, hs, term);

      // Back-pressure: result held while in_valid keeps pushing.
      drive_cycle(1'b1, 100, 1'b0, 1'b0, hs, term);
      drive_cycle(1'b1, 50, 1'b1, 1'b0, hs, term);
      for (int k = 0; k < 5; k++) begin
         drive_cycle(1'b1, 77, 1'b1, 1'b0, hs, term);
         expect_result("bp_hold", 37, 2, 1'b0);
         chk("bp_in_ready", int'(in_ready), 0);
      end
      drive_cycle(1'b0, 0, 1'b0, 1'b1, hs, term);
      chk("bp_release_ready", int'(in_ready), 1);
      chk("bp_release_valid", int'(out_valid), 0);
      drive_cycle(1'b1, 5, 1'b1, 1'b1, hs, term);
      expect_result("bp_next", 5, 1, 1'b0);
      drive_cycle(1'b0, 0, 1'b0, 1'b1, hs, term);

      // Reset mid-frame with a concurrent handshake; nothing is emitted.
      for (int k = 0; k < 3; k++) drive_cycle(1'b1, 40 + k, 1'b0, 1'b1, hs, term);
      do_reset(1'b1);
      for (int k = 0; k < 3; k++) begin
         drive_cycle(1'b0, 0, 1'b0, 1'b1, hs, term);
         chk("rst_no_valid", int'(out_valid), 0);
      end
      drive_cycle(1'b1, 60, 1'b0, 1'b1, hs, term);
      drive_cycle(1'b1, 60, 1'b1, 1'b1, hs, term);
      expect_result("post_rst", 7, 2, 1'b0);
      drive_cycle(1'b0, 0, 1'b0, 1'b1, hs, term);

      // Random frames with input gaps and random back-pressure.
      len = int'($urandom_range(1, 84));
      idx = 0;
      frames = 0;
      for (int cyc = 0; cyc < 20000 && frames < 40; cyc++) begin
         drive_cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 127)),
                     idx == len - 1, $urandom_range(0, 1) == 1, hs, term);
         if (hs) idx++;
         if (term) begin
            frames++;
            idx = 0;
            len = int'($urandom_range(1, 84));
         end
      end
      chk("rand_frames_done", frames, 40);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mod113_residue_accumulator.md
# mod113_residue_accumulator

Sequential reduction stage directly downstream of the per-chunk mod-113 residue LUTs. Accepts one 7-bit weighted partial residue per handshake, where each residue is one 6-bit input chunk already multiplied by its 2^(6k) weight, from the LUT bank. Keeps a running sum modulo 113 and emits the canonical residue of the whole operand (up to 500 bits, 84 chunks) once the frame's last term is accepted. Output is registered and held under back-pressure.

## Interface
- `MAX_TERMS`, default 84: maximum terms per frame. A frame longer than this is force-terminated.
- `CNT_W`, default 7: width of the term counter. Must satisfy 2^CNT_W > MAX_TERMS.
- `clk` in 1: the single clock. All state changes on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `in_valid` in 1: `in_data` and `in_last` are valid this cycle.
- `in_ready` out 1: the block can accept a term this cycle.
- `in_data` in 7: partial residue, 0..127. Values 113..127 (non-canonical) are legal.
- `in_last` in 1: this term closes the frame.
- `out_valid` out 1: the final residue is presented.
- `out_ready` in 1: downstream accepts the result.
- `out_residue` out 7: frame sum mod 113, always 0..112.
- `out_count` out CNT_W: number of terms accepted in the frame.
- `out_overflow` out 1: the frame was force-terminated at `MAX_TERMS`.

## Operation
- States: IDLE, ACCUM, DONE. Reset enters IDLE with acc=0 and cnt=0.
- `in_ready` = 1 in IDLE and ACCUM, 0 in DONE. An input handshake is `in_valid & in_ready`.
- Reduction step: s = acc + in_data (9 bits, maximum 112+127=239).
  - If s ≥ 226: next = s−226.
  - Else if s ≥ 113: next = s−113.
  - Else: next = s.
  - Result is always 0..112.
- Handshake in IDLE or ACCUM, non-terminating: acc←next, cnt←cnt+1, state←ACCUM.
- Terminating handshake: `in_last`=1, or cnt==MAX_TERMS−1.
  - `out_residue`←next, `out_count`←cnt+1.
  - `out_overflow`←(~in_last & cnt==MAX_TERMS−1).
  - acc←0, cnt←0, state←DONE.
- In DONE, `out_valid`=1 and all outputs are held stable until `out_ready`=1. On that cycle state←IDLE.
- No handshake: acc, cnt and state hold. `in_valid` gaps within a frame are allowed.
- `rst` mid-frame or in DONE discards the partial sum and any pending result. No output is emitted.
- `in_data` is ignored whenever there is no handshake. X on `in_data` without `in_valid` must not propagate into acc.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_residue`=0, `out_count`=0, `out_overflow`=0.
- Latency: `out_valid` rises on the cycle after the terminating handshake.
- Throughput: one term per cycle within a frame. Minimum gap between frames is 1 cycle: the DONE cycle with `out_ready`=1. The next term can be accepted on the following cycle (IDLE). There is no same-cycle bypass from output release to input accept.
- With `out_ready` held 1, a frame of N terms occupies N+1 cycles.
- `in_ready` is a registered function of state. It has no combinational path from `in_valid` or `out_ready`.
- When `rst` and a handshake occur in the same cycle, `rst` wins.

## Structure
- Package `mod113_pkg` holds:
  - `MODULUS`=113 and `RES_W`=7.
  - The state enum {IDLE, ACCUM, DONE}.
  - Function `mod113_reduce(9-bit s)` implementing the two-threshold subtraction.
- Sub-module `mod113_add_reduce`: combinational, a[6:0] + b[6:0] → canonical 7-bit sum mod 113. The team also reuses it in the parallel adder tree.
- Top level holds the FSM, acc, cnt and output registers.

## Test plan
- Two-term frame 112, 127 (last on 127) → `out_residue`=13, `out_count`=2, `out_overflow`=0, `out_valid` one cycle after the second accept.
- Single term 113 with last → `out_residue`=0. Single term 127 with last → 14.
- 84 terms of value 1, `in_last` never asserted → after the 84th accept, `out_residue`=84, `out_count`=84, `out_overflow`=1. The next frame starts clean.
- Back-pressure: frame 100, 50 (result 37), with `out_ready`=0 for 5 cycles.
  - Outputs are held stable throughout and `in_ready`=0.
  - On `out_ready`=1, `in_ready` returns to 1 the next cycle.
  - A following frame 5 (last) → 5.
- `rst` asserted after 3 of 6 terms → no `out_valid`. Then frame 60, 60 → 7.
- Random frames of 1..84 terms with random `in_valid` gaps and random `out_ready` → every result matches a golden Σ mod 113.
